// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch-stage PC / instruction-request unit.
//   fetch_state_t    : request FSM states
//                      IDLE : post-reset, about to launch the first request
//                      WAIT : request outstanding, response will be kept
//                      HOLD : instruction buffered and presented to IF/ID
//                      DROP : request outstanding, response will be discarded
//   NOP_INSTR        : addi x0,x0,0, the buffered instruction after reset
//   DEFAULT_RESET_PC : PC used when the instantiating level does not override
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit_if
// Instruction-memory request/response channel (single outstanding request).
//   imem_req    : request valid, held until the response cycle
//   imem_addr   : request address, stable while imem_req is high
//   imem_rvalid : response valid, terminates the current request
//   imem_rdata  : instruction word, meaningful with imem_rvalid
// Modports:
//   master : fetch side (drives req/addr)
//   slave  : memory side (drives rvalid/rdata)
// ---------------------------------------------------------------------------
interface fetch_pc_unit_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_rvalid;
  logic [DATA_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
// Fetch-stage program counter and instruction-request engine. Keeps the PC,
// launches one instruction-memory request at a time, buffers the returned
// instruction for the IF/ID register and reports a memory stall whenever no
// instruction is available. Execute-stage redirects override sequential
// advance; a redirect that arrives while a request is in flight turns that
// request into a "drop" whose response is thrown away.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   F_PCEn       : advance to pc+4 (only honoured while an instruction is held)
//   E_PCSrc      : redirect request from Execute (wins over F_PCEn)
//   E_PCTarget   : redirect target, bits [1:0] ignored (word aligned)
//   imem         : instruction-memory channel, master side
//   F_Instr      : buffered instruction
//   F_PC         : address of F_Instr (current PC)
//   F_PCPlus4    : F_PC + 4, wrapping modulo 2^DATA_WIDTH
//   F_Valid      : F_Instr is valid
//   F_MemStall   : no instruction available (~F_Valid)
// ---------------------------------------------------------------------------
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  F_PCEn,
  input  logic                  E_PCSrc,
  input  logic [DATA_WIDTH-1:0] E_PCTarget,
  fetch_pc_unit_if.master       imem,
  output logic [DATA_WIDTH-1:0] F_Instr,
  output logic [DATA_WIDTH-1:0] F_PC,
  output logic [DATA_WIDTH-1:0] F_PCPlus4,
  output logic                  F_Valid,
  output logic                  F_MemStall
);

  fetch_state_t          state_reg, state_next;
  logic [DATA_WIDTH-1:0] pc_reg, pc_next;
  logic [DATA_WIDTH-1:0] req_addr_reg, req_addr_next;
  logic [DATA_WIDTH-1:0] instr_q_reg, instr_q_next;

  logic [DATA_WIDTH-1:0] target_aligned;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic                  unused_target_bits;

  // Instructions are word aligned; the low target bits carry no address.
  assign target_aligned     = {E_PCTarget[DATA_WIDTH-1:2], 2'b00};
  assign unused_target_bits = ^E_PCTarget[1:0];

  // Natural wrap of the adder gives 0xFFFF_FFFC + 4 = 0.
  assign pc_plus4 = pc_reg + DATA_WIDTH'(4);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      req_addr_reg <= RESET_PC;
      instr_q_reg  <= DATA_WIDTH'(NOP_INSTR);
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      req_addr_reg <= req_addr_next;
      instr_q_reg  <= instr_q_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    req_addr_next = req_addr_reg;
    instr_q_next  = instr_q_reg;

    unique case (state_reg)
      IDLE: begin
        // Launch the first request. A redirect arriving in this single
        // cycle is still honoured so it cannot be lost.
        if (E_PCSrc) begin
          pc_next       = target_aligned;
          req_addr_next = target_aligned;
        end else begin
          req_addr_next = pc_reg;
        end
        state_next = WAIT;
      end

      WAIT: begin
        if (imem.imem_rvalid && !E_PCSrc) begin
          instr_q_next = imem.imem_rdata;
          state_next   = HOLD;
        end else if (imem.imem_rvalid && E_PCSrc) begin
          // Response belongs to the wrong path; the request has ended, so
          // a fresh one to the target can start right away.
          pc_next       = target_aligned;
          req_addr_next = target_aligned;
        end else if (E_PCSrc) begin
          // Request still in flight; its response must be swallowed before
          // the target can be fetched.
          pc_next    = target_aligned;
          state_next = DROP;
        end
      end

      DROP: begin
        if (E_PCSrc) begin
          pc_next = target_aligned;
        end
        if (imem.imem_rvalid) begin
          // Fetch from the newest PC, including a redirect in this cycle.
          req_addr_next = E_PCSrc ? target_aligned : pc_reg;
          state_next    = WAIT;
        end
      end

      HOLD: begin
        if (E_PCSrc) begin
          pc_next       = target_aligned;
          req_addr_next = target_aligned;
          state_next    = WAIT;
        end else if (F_PCEn) begin
          pc_next       = pc_plus4;
          req_addr_next = pc_plus4;
          state_next    = WAIT;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign imem.imem_req  = (state_reg == WAIT) || (state_reg == DROP);
  assign imem.imem_addr = req_addr_reg;

  assign F_Instr    = instr_q_reg;
  assign F_PC       = pc_reg;
  assign F_PCPlus4  = pc_plus4;
  assign F_Valid    = (state_reg == HOLD);
  assign F_MemStall = (state_reg != HOLD);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_unit
// Directed bench for fetch_pc_unit. A bench-side instruction memory answers
// each request after a programmable number of request cycles (1 = response
// in the first request cycle). A flag-based reference model tracks what the
// fetch unit must present; a compare process checks every output on every
// falling edge, and literal checks pin the model at the interesting points.
// ---------------------------------------------------------------------------
module tb_fetch_pc_unit;
  import fetch_pkg::*;

  localparam int          W     = 32;
  localparam logic [31:0] RPC   = 32'h0040_0000;
  localparam logic [31:0] SALT  = 32'hC0DE_0003;

  logic         clk = 1'b0;
  logic         rst;
  logic         F_PCEn;
  logic         E_PCSrc;
  logic [W-1:0] E_PCTarget;
  logic [W-1:0] F_Instr;
  logic [W-1:0] F_PC;
  logic [W-1:0] F_PCPlus4;
  logic         F_Valid;
  logic         F_MemStall;

  always #5 clk = ~clk;

  fetch_pc_unit_if #(.DATA_WIDTH(W)) imem_bus ();

  fetch_pc_unit #(
    .DATA_WIDTH(W),
    .RESET_PC  (RPC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .F_PCEn    (F_PCEn),
    .E_PCSrc   (E_PCSrc),
    .E_PCTarget(E_PCTarget),
    .imem      (imem_bus),
    .F_Instr   (F_Instr),
    .F_PC      (F_PC),
    .F_PCPlus4 (F_PCPlus4),
    .F_Valid   (F_Valid),
    .F_MemStall(F_MemStall)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Memory contents: address-derived so every fetched word is distinct.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ SALT;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_fetch_addr, m_instr;
  bit          m_busy, m_stale, m_valid, m_boot;

  task automatic model_update(input bit r, input bit pcen, input bit pcsrc,
                              input logic [31:0] tgt, input bit rv,
                              input logic [31:0] rd);
    logic [31:0] t;
    t = {tgt[31:2], 2'b00};
    if (r) begin
      m_pc = RPC; m_fetch_addr = RPC; m_instr = NOP_INSTR;
      m_busy = 0; m_stale = 0; m_valid = 0; m_boot = 1;
    end else if (m_boot) begin
      m_boot = 0;
      m_busy = 1;
      if (pcsrc) m_pc = t;
      m_fetch_addr = m_pc;
    end else if (m_busy) begin
      if (pcsrc) begin
        m_pc = t;
        if (rv) begin m_fetch_addr = t; m_stale = 0; end
        else m_stale = 1;
      end else if (rv) begin
        if (m_stale) begin m_stale = 0; m_fetch_addr = m_pc; end
        else begin m_instr = rd; m_valid = 1; m_busy = 0; end
      end
    end else if (m_valid) begin
      if (pcsrc) begin
        m_pc = t; m_fetch_addr = t; m_valid = 0; m_busy = 1;
      end else if (pcen) begin
        m_pc = m_pc + 32'd4; m_fetch_addr = m_pc; m_valid = 0; m_busy = 1;
      end
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req",   {31'd0, imem_bus.imem_req}, {31'd0, m_busy});
      chk("imem_addr",  imem_bus.imem_addr, m_fetch_addr);
      chk("F_Valid",    {31'd0, F_Valid}, {31'd0, m_valid});
      chk("F_MemStall", {31'd0, F_MemStall}, {31'd0, !m_valid});
      chk("F_PC",       F_PC, m_pc);
      chk("F_PCPlus4",  F_PCPlus4, m_pc + 32'd4);
      chk("F_Instr",    F_Instr, m_instr);
    end
  end

  // ---------------- memory + stimulus ----------------
  int          mem_lat = 1;
  int          mem_age = 0;
  logic [31:0] req_log[$];

  // Called at a falling edge; applies one cycle of inputs and returns at the
  // next falling edge.
  task automatic step(input bit pcen, input bit pcsrc, input logic [31:0] tgt);
    bit          rv;
    logic [31:0] rd;
    if (imem_bus.imem_req === 1'b1) begin
      mem_age++;
      if (mem_age == 1) req_log.push_back(imem_bus.imem_addr);
    end else begin
      mem_age = 0;
    end
    rv = (imem_bus.imem_req === 1'b1) && (mem_age >= mem_lat);
    rd = rv ? mem_word(imem_bus.imem_addr) : 32'hDEAD_BEEF;
    imem_bus.imem_rvalid = rv;
    imem_bus.imem_rdata  = rd;
    F_PCEn     = pcen;
    E_PCSrc    = pcsrc;
    E_PCTarget = tgt;
    @(posedge clk);
    #1;
    model_update(rst, pcen, pcsrc, tgt, rv, rd);
    if (rv) mem_age = 0;
    @(negedge clk);
    $display("cyc t=%0t rst=%0b pcen=%0b pcsrc=%0b tgt=%h rv=%0b -> req=%0b addr=%h valid=%0b pc=%h instr=%h",
             $time, rst, pcen, pcsrc, tgt, rv, imem_bus.imem_req, imem_bus.imem_addr,
             F_Valid, F_PC, F_Instr);
  endtask

  initial begin
    logic [5:0] vhist;
    int         n0;

    rst = 1'b1;
    F_PCEn = 0; E_PCSrc = 0; E_PCTarget = '0;
    imem_bus.imem_rvalid = 0; imem_bus.imem_rdata = '0;

    // ---- reset ----
    step(0, 0, 32'h0);
    chk_en = 1'b1;
    step(0, 0, 32'h0);
    chk("rst imem_req",   {31'd0, imem_bus.imem_req}, 32'd0);
    chk("rst F_MemStall", {31'd0, F_MemStall}, 32'd1);
    chk("rst F_PC",       F_PC, 32'h0040_0000);
    chk("rst F_Instr",    F_Instr, 32'h0000_0013);
    rst = 1'b0;

    // ---- sequential fetch, 1-cycle memory, F_PCEn held ----
    mem_lat = 1;
    req_log.delete();
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 32'h0);
      vhist[i] = F_Valid;
    end
    chk("seq valid pattern", {26'd0, vhist}, 32'h0000_002A);
    chk("seq req count", req_log.size(), 32'd3);
    if (req_log.size() >= 3) begin
      chk("seq addr0", req_log[0], 32'h0040_0000);
      chk("seq addr1", req_log[1], 32'h0040_0004);
      chk("seq addr2", req_log[2], 32'h0040_0008);
    end

    // ---- hold with F_PCEn low ----
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 32'h0);
      chk("hold F_Instr",   F_Instr, 32'hC09E_000B);
      chk("hold F_PC",      F_PC, 32'h0040_0008);
      chk("hold imem_req",  {31'd0, imem_bus.imem_req}, 32'd0);
      chk("hold F_MemStall",{31'd0, F_MemStall}, 32'd0);
    end

    // ---- redirect in HOLD beats F_PCEn ----
    n0 = req_log.size();
    step(1, 1, 32'h0040_0102);
    chk("redir imem_addr", imem_bus.imem_addr, 32'h0040_0100);
    chk("redir imem_req",  {31'd0, imem_bus.imem_req}, 32'd1);
    step(1, 0, 32'h0);
    chk("redir F_Instr", F_Instr, 32'hC09E_0103);
    chk("redir F_PC",    F_PC, 32'h0040_0100);
    chk("redir one req", req_log.size() - n0, 32'd1);

    // ---- redirect during WAIT, latency 3 -> DROP path ----
    mem_lat = 3;
    step(1, 0, 32'h0);                       // HOLD -> WAIT @0x00400104
    step(0, 0, 32'h0);                       // age 1
    step(0, 1, 32'h0040_0200);               // age 2, redirect
    chk("drop F_PC",      F_PC, 32'h0040_0200);
    chk("drop F_Valid",   {31'd0, F_Valid}, 32'd0);
    chk("drop imem_addr", imem_bus.imem_addr, 32'h0040_0104);
    step(0, 0, 32'h0);                       // age 3, old response discarded
    chk("drop discard valid", {31'd0, F_Valid}, 32'd0);
    chk("drop new addr", imem_bus.imem_addr, 32'h0040_0200);
    for (int i = 0; i < 3; i++) step(0, 0, 32'h0);
    chk("drop F_Valid",   {31'd0, F_Valid}, 32'd1);
    chk("drop F_Instr",   F_Instr, 32'hC09E_0203);
    chk("drop F_PC end",  F_PC, 32'h0040_0200);

    // ---- redirect in the same cycle as rvalid ----
    mem_lat = 1;
    step(1, 0, 32'h0);                       // -> WAIT @0x00400204
    step(0, 1, 32'h0040_0300);               // rvalid + redirect
    chk("same F_Valid",   {31'd0, F_Valid}, 32'd0);
    chk("same imem_addr", imem_bus.imem_addr, 32'h0040_0300);
    chk("same F_Instr",   F_Instr, 32'hC09E_0203);
    step(0, 0, 32'h0);
    chk("same new instr", F_Instr, 32'hC09E_0303);

    // ---- PC wrap ----
    step(0, 1, 32'hFFFF_FFFF);
    step(0, 0, 32'h0);
    chk("wrap F_PC",      F_PC, 32'hFFFF_FFFC);
    chk("wrap F_PCPlus4", F_PCPlus4, 32'h0000_0000);
    step(1, 0, 32'h0);
    chk("wrap imem_addr", imem_bus.imem_addr, 32'h0000_0000);
    step(0, 0, 32'h0);
    chk("wrap F_Instr",   F_Instr, 32'hC0DE_0003);

    // ---- reset in the middle of a request ----
    mem_lat = 3;
    step(1, 0, 32'h0);
    step(0, 0, 32'h0);
    rst = 1'b1;
    step(0, 0, 32'h0);
    chk("mid-rst imem_req", {31'd0, imem_bus.imem_req}, 32'd0);
    chk("mid-rst F_PC",     F_PC, 32'h0040_0000);
    rst = 1'b0;

    // ---- mixed traffic, model-checked ----
    for (int i = 0; i < 60; i++) begin
      mem_lat = $urandom_range(1, 3);
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
           {16'h0040, 16'($urandom)});
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
